// File: rtl/mshr_miss_ctrl.sv
// Non-blocking L1 miss controller: DEPTH-entry MSHR file, dirty-victim writeback ahead of refill, tagged out-of-order completion.
// A clean miss reaches L2 two cycles after acceptance; l2_stall holds only the issue FSM, and fill_we follows l2_done by one cycle regardless.
module mshr_miss_ctrl #(
    parameter int ADDR_W     = 26,
    parameter int DEPTH      = 4,
    parameter int L2_CLK_DIV = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      miss_valid,
    input  logic [ADDR_W-1:0]         miss_addr,
    input  logic                      miss_dirty,
    input  logic [ADDR_W-1:0]         miss_victim_addr,
    input  logic                      lookup_valid,
    input  logic [ADDR_W-1:0]         lookup_addr,
    input  logic                      l2_stall,
    input  logic                      l2_done,
    input  logic [$clog2(DEPTH)-1:0]  l2_done_tag,
    output logic                      l2_valid,
    output logic                      l2_rw,
    output logic [ADDR_W-1:0]         l2_addr,
    output logic [$clog2(DEPTH)-1:0]  l2_tag,
    output logic                      wb_rd_valid,
    output logic                      fill_we,
    output logic [ADDR_W-1:0]         fill_addr,
    output logic                      stall_out,
    output logic [$clog2(DEPTH):0]    mshr_count,
    output logic                      protocol_err
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CW    = TAG_W + 1;
    localparam int HOLD  = 2 * L2_CLK_DIV + 1;
    localparam int CNT_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {IDLE, WB_ISSUE, WB_HOLD, RD_ISSUE} state_t;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_issued;
    logic [DEPTH-1:0]  ent_dirty;
    logic [ADDR_W-1:0] ent_addr   [DEPTH];
    logic [ADDR_W-1:0] ent_victim [DEPTH];

    state_t            state;
    logic [TAG_W-1:0]  sel;
    logic [CNT_W-1:0]  hold_cnt;

    logic              miss_hit;
    logic              look_hit;
    logic              pend_found;
    logic              full;
    logic              alloc;
    logic              done_ok;
    logic              issue_rd;
    logic [TAG_W-1:0]  free_idx;
    logic [TAG_W-1:0]  pend_idx;

    // Descending scan so the lowest index wins both priority picks.
    always_comb begin
        miss_hit   = 1'b0;
        look_hit   = 1'b0;
        pend_found = 1'b0;
        free_idx   = '0;
        pend_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_idx = TAG_W'(i);
            end
            if (ent_valid[i] && !ent_issued[i]) begin
                pend_found = 1'b1;
                pend_idx   = TAG_W'(i);
            end
            if (ent_valid[i] && ent_addr[i] == miss_addr) begin
                miss_hit = 1'b1;
            end
            if (ent_valid[i] && ent_addr[i] == lookup_addr) begin
                look_hit = 1'b1;
            end
        end
    end

    assign full      = &ent_valid;
    assign alloc     = miss_valid && !full && !miss_hit;
    assign done_ok   = l2_done && ent_valid[l2_done_tag] && ent_issued[l2_done_tag];
    assign issue_rd  = (state == RD_ISSUE) && !l2_stall;
    assign stall_out = (lookup_valid && look_hit) || (miss_valid && full);

    // Alloc, issue and completion always touch distinct slots, so their updates never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_valid    <= '0;
            ent_issued   <= '0;
            ent_dirty    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i]   <= '0;
                ent_victim[i] <= '0;
            end
            fill_we      <= 1'b0;
            fill_addr    <= '0;
            protocol_err <= 1'b0;
            mshr_count   <= '0;
        end else begin
            if (alloc) begin
                ent_valid[free_idx]  <= 1'b1;
                ent_issued[free_idx] <= 1'b0;
                ent_dirty[free_idx]  <= miss_dirty;
                ent_addr[free_idx]   <= miss_addr;
                ent_victim[free_idx] <= miss_victim_addr;
            end
            if (issue_rd) begin
                ent_issued[sel] <= 1'b1;
            end
            if (done_ok) begin
                ent_valid[l2_done_tag]  <= 1'b0;
                ent_issued[l2_done_tag] <= 1'b0;
                fill_addr               <= ent_addr[l2_done_tag];
            end
            fill_we <= done_ok;
            if (l2_done && !done_ok) begin
                protocol_err <= 1'b1;
            end
            mshr_count <= mshr_count + CW'(alloc) - CW'(done_ok);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= '0;
            hold_cnt    <= '0;
            l2_valid    <= 1'b0;
            l2_rw       <= 1'b0;
            l2_addr     <= '0;
            l2_tag      <= '0;
            wb_rd_valid <= 1'b0;
        end else begin
            l2_valid <= 1'b0;
            l2_rw    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_found && !l2_stall) begin
                        sel   <= pend_idx;
                        state <= ent_dirty[pend_idx] ? WB_ISSUE : RD_ISSUE;
                    end
                end
                WB_ISSUE: begin
                    l2_valid    <= 1'b1;
                    l2_rw       <= 1'b1;
                    l2_addr     <= ent_victim[sel];
                    wb_rd_valid <= 1'b1;
                    hold_cnt    <= CNT_W'(1);
                    state       <= WB_HOLD;
                end
                WB_HOLD: begin
                    // The last hold step waits for L2 so victim data stays valid until it is taken.
                    if (hold_cnt == CNT_W'(HOLD)) begin
                        if (!l2_stall) begin
                            wb_rd_valid <= 1'b0;
                            state       <= RD_ISSUE;
                        end
                    end else if (hold_cnt != CNT_W'(HOLD - 1) || !l2_stall) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                RD_ISSUE: begin
                    if (!l2_stall) begin
                        l2_valid <= 1'b1;
                        l2_addr  <= ent_addr[sel];
                        l2_tag   <= sel;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mshr_miss_ctrl.sv
// Directed bench for mshr_miss_ctrl: per-cycle vector table for clean/dirty misses, then hand-timed multi-cycle sequences.
module tb_mshr_miss_ctrl;
    localparam int AW = 26;
    localparam int NV = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          miss_valid, miss_dirty, lookup_valid, l2_stall, l2_done;
    logic [AW-1:0] miss_addr, miss_victim_addr, lookup_addr;
    logic [1:0]    l2_done_tag;
    logic          l2_valid, l2_rw, wb_rd_valid, fill_we, stall_out, protocol_err;
    logic [AW-1:0] l2_addr, fill_addr;
    logic [1:0]    l2_tag;
    logic [2:0]    mshr_count;

    mshr_miss_ctrl dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
        .miss_victim_addr(miss_victim_addr), .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .l2_stall(l2_stall), .l2_done(l2_done), .l2_done_tag(l2_done_tag),
        .l2_valid(l2_valid), .l2_rw(l2_rw), .l2_addr(l2_addr), .l2_tag(l2_tag),
        .wb_rd_valid(wb_rd_valid), .fill_we(fill_we), .fill_addr(fill_addr),
        .stall_out(stall_out), .mshr_count(mshr_count), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          miss_valid;
        logic [AW-1:0] miss_addr;
        logic          miss_dirty;
        logic [AW-1:0] miss_victim_addr;
        logic          lookup_valid;
        logic [AW-1:0] lookup_addr;
        logic          l2_done;
        logic [1:0]    l2_done_tag;
        logic          e_l2_valid;
        logic          e_l2_rw;
        logic [AW-1:0] e_l2_addr;
        logic [1:0]    e_l2_tag;
        logic          e_wb;
        logic          e_fill;
        logic [AW-1:0] e_fill_addr;
        logic          e_stall;
        logic [2:0]    e_count;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    tag;
        int            cyc;
    } rec_t;

    vec_t tbl [NV];
    rec_t rd_q[$];
    rec_t wb_q[$];
    rec_t fill_q[$];
    int   cyc    = 0;
    int   wb_hi  = 0;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            if (l2_valid && !l2_rw) rd_q.push_back('{l2_addr, l2_tag, cyc});
            if (l2_valid && l2_rw)  wb_q.push_back('{l2_addr, 2'd0, cyc});
            if (fill_we)            fill_q.push_back('{fill_addr, 2'd0, cyc});
            if (wb_rd_valid)        wb_hi = wb_hi + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, " l2_valid"}, l2_valid, 0);
        chk({p, " l2_rw"}, l2_rw, 0);
        chk({p, " l2_addr"}, l2_addr, 0);
        chk({p, " l2_tag"}, l2_tag, 0);
        chk({p, " wb_rd_valid"}, wb_rd_valid, 0);
        chk({p, " fill_we"}, fill_we, 0);
        chk({p, " fill_addr"}, fill_addr, 0);
        chk({p, " stall_out"}, stall_out, 0);
        chk({p, " mshr_count"}, mshr_count, 0);
        chk({p, " protocol_err"}, protocol_err, 0);
    endtask

    function automatic int qsize(input int which);
        if (which == 0) return rd_q.size();
        if (which == 1) return wb_q.size();
        return fill_q.size();
    endfunction

    task automatic wait_q(input string nm, input int which, input int n);
        int k = 0;
        while (qsize(which) < n && k < 300) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk({nm, " arrived"}, qsize(which) >= n, 1);
    endtask

    task automatic chk_rd(input string nm, input int k, input logic [AW-1:0] a, input logic [1:0] t);
        if (rd_q.size() > k) begin
            chk({nm, " addr"}, rd_q[k].addr, a);
            chk({nm, " tag"}, rd_q[k].tag, t);
        end else begin
            chk({nm, " present"}, rd_q.size(), k + 1);
        end
    endtask

    task automatic reset_log();
        #1;
        rd_q.delete();
        wb_q.delete();
        fill_q.delete();
        wb_hi = 0;
    endtask

    task automatic s_miss(input int i, input logic [AW-1:0] a, input logic d, input logic [AW-1:0] vic);
        tbl[i].miss_valid = 1'b1;
        tbl[i].miss_addr = a;
        tbl[i].miss_dirty = d;
        tbl[i].miss_victim_addr = vic;
    endtask

    task automatic s_look(input int i, input logic [AW-1:0] a, input logic st);
        tbl[i].lookup_valid = 1'b1;
        tbl[i].lookup_addr = a;
        tbl[i].e_stall = st;
    endtask

    task automatic e_l2(input int i, input logic rw, input logic [AW-1:0] a, input logic [1:0] t);
        tbl[i].e_l2_valid = 1'b1;
        tbl[i].e_l2_rw = rw;
        tbl[i].e_l2_addr = a;
        tbl[i].e_l2_tag = t;
    endtask

    task automatic e_wbv(input int i, input logic [AW-1:0] a);
        tbl[i].e_wb = 1'b1;
        tbl[i].e_l2_addr = a;
    endtask

    initial begin
        int order [4];
        vec_t v;
        order = '{0, 1, 3, 2};

        foreach (tbl[i]) tbl[i] = '{default: '0};
        // Clean miss on 0x100 with same-line lookups and a secondary miss.
        s_miss(0, 26'h100, 1'b0, 26'h0);
        e_l2(3, 1'b0, 26'h100, 2'd0);
        s_look(4, 26'h100, 1'b1);
        s_miss(4, 26'h100, 1'b0, 26'h0);
        s_look(5, 26'h100, 1'b1);
        s_look(6, 26'h100, 1'b1);
        tbl[6].l2_done = 1'b1;
        tbl[6].l2_done_tag = 2'd0;
        s_look(7, 26'h100, 1'b0);
        tbl[7].e_fill = 1'b1;
        tbl[7].e_fill_addr = 26'h100;
        // Dirty miss: writeback pulse, three wb_rd_valid cycles, then the refill read.
        s_miss(9, 26'h200, 1'b1, 26'h2A0);
        e_l2(12, 1'b1, 26'h2A0, 2'd0);
        e_wbv(12, 26'h2A0);
        e_wbv(13, 26'h2A0);
        e_wbv(14, 26'h2A0);
        e_l2(16, 1'b0, 26'h200, 2'd0);
        tbl[18].l2_done = 1'b1;
        tbl[18].l2_done_tag = 2'd0;
        tbl[19].e_fill = 1'b1;
        tbl[19].e_fill_addr = 26'h200;
        for (int i = 1; i <= 6; i++) tbl[i].e_count = 3'd1;
        for (int i = 10; i <= 18; i++) tbl[i].e_count = 3'd1;

        miss_valid = 0; miss_addr = 0; miss_dirty = 0; miss_victim_addr = 0;
        lookup_valid = 0; lookup_addr = 0; l2_stall = 0; l2_done = 0; l2_done_tag = 0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            miss_valid = v.miss_valid; miss_addr = v.miss_addr; miss_dirty = v.miss_dirty;
            miss_victim_addr = v.miss_victim_addr; lookup_valid = v.lookup_valid;
            lookup_addr = v.lookup_addr; l2_done = v.l2_done; l2_done_tag = v.l2_done_tag;
            #1;
            chk($sformatf("v%0d l2_valid", i), l2_valid, v.e_l2_valid);
            chk($sformatf("v%0d wb_rd_valid", i), wb_rd_valid, v.e_wb);
            chk($sformatf("v%0d fill_we", i), fill_we, v.e_fill);
            chk($sformatf("v%0d stall_out", i), stall_out, v.e_stall);
            chk($sformatf("v%0d mshr_count", i), mshr_count, v.e_count);
            chk($sformatf("v%0d protocol_err", i), protocol_err, 0);
            if (v.e_l2_valid) chk($sformatf("v%0d l2_rw", i), l2_rw, v.e_l2_rw);
            if (v.e_l2_valid || v.e_wb) chk($sformatf("v%0d l2_addr", i), l2_addr, v.e_l2_addr);
            if (v.e_l2_valid && !v.e_l2_rw) chk($sformatf("v%0d l2_tag", i), l2_tag, v.e_l2_tag);
            if (v.e_fill) chk($sformatf("v%0d fill_addr", i), fill_addr, v.e_fill_addr);
            @(negedge clock);
        end
        miss_valid = 0; lookup_valid = 0; l2_done = 0;

        // Dirty miss with l2_stall held for 4 cycles at the end of the hold window.
        reset_log();
        @(negedge clock);
        miss_valid = 1; miss_addr = 26'h300; miss_dirty = 1; miss_victim_addr = 26'h2A0;
        @(negedge clock);
        miss_valid = 0; miss_dirty = 0;
        wait_q("stall wb", 1, 1);
        @(negedge clock);
        l2_stall = 1;
        repeat (4) @(negedge clock);
        l2_stall = 0;
        wait_q("stall rd", 0, 1);
        if (rd_q.size() > 0 && wb_q.size() > 0) begin
            chk("stall wb addr", wb_q[0].addr, 26'h2A0);
            chk("stall rd delay", rd_q[0].cyc - wb_q[0].cyc, 8);
        end
        chk_rd("stall rd", 0, 26'h300, 2'd0);
        chk("stall wb_rd_valid cycles", wb_hi, 7);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 0;
        @(negedge clock);
        l2_done = 0;
        #1;
        chk("stall fill_we", fill_we, 1);
        chk("stall fill_addr", fill_addr, 26'h300);
        chk("stall count", mshr_count, 0);

        // Four misses fill the file; a fifth waits for a freed slot.
        reset_log();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            miss_valid = 1; miss_addr = AW'((k + 1) * 16);
        end
        @(negedge clock);
        miss_valid = 0;
        wait_q("full rd", 0, 4);
        for (int k = 0; k < 4; k++) chk_rd($sformatf("full rd%0d", k), k, AW'((k + 1) * 16), 2'(k));
        chk("full count", mshr_count, 4);
        @(negedge clock);
        miss_valid = 1; miss_addr = 26'h50;
        #1;
        chk("full stall_out", stall_out, 1);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 2;
        #1;
        chk("full no alloc count", mshr_count, 4);
        chk("full stall on free cycle", stall_out, 1);
        @(negedge clock);
        l2_done = 0;
        #1;
        chk("freed count", mshr_count, 3);
        chk("freed stall_out", stall_out, 0);
        @(negedge clock);
        miss_valid = 0;
        #1;
        chk("realloc count", mshr_count, 4);
        if (fill_q.size() > 0) chk("free fill_addr", fill_q[0].addr, 26'h30);
        else chk("free fill present", fill_q.size(), 1);
        wait_q("realloc rd", 0, 5);
        chk_rd("realloc rd", 4, 26'h50, 2'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            l2_done = 1; l2_done_tag = 2'(order[k]);
        end
        @(negedge clock);
        l2_done = 0;
        repeat (2) @(negedge clock);
        #1;
        chk("drain count", mshr_count, 0);

        // Out-of-order completion, with an alloc landing in the same cycle as a free.
        reset_log();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            miss_valid = 1; miss_addr = AW'((k + 1) * 16);
        end
        @(negedge clock);
        miss_valid = 0;
        wait_q("ooo rd", 0, 4);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 3;
        @(negedge clock);
        l2_done_tag = 1; miss_valid = 1; miss_addr = 26'h80;
        #1;
        chk("ooo count after free", mshr_count, 3);
        @(negedge clock);
        l2_done_tag = 0; miss_valid = 0;
        #1;
        chk("ooo alloc+free count", mshr_count, 3);
        @(negedge clock);
        l2_done_tag = 2;
        @(negedge clock);
        l2_done = 0;
        wait_q("ooo new rd", 0, 5);
        chk_rd("ooo new rd", 4, 26'h80, 2'd3);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 3;
        @(negedge clock);
        l2_done = 0;
        wait_q("ooo fills", 2, 5);
        if (fill_q.size() >= 5) begin
            chk("ooo fill0", fill_q[0].addr, 26'h40);
            chk("ooo fill1", fill_q[1].addr, 26'h20);
            chk("ooo fill2", fill_q[2].addr, 26'h10);
            chk("ooo fill3", fill_q[3].addr, 26'h30);
            chk("ooo fill4", fill_q[4].addr, 26'h80);
        end
        chk("ooo count", mshr_count, 0);

        // Completion of one entry while another sits in its writeback hold.
        reset_log();
        @(negedge clock);
        miss_valid = 1; miss_addr = 26'h500;
        @(negedge clock);
        miss_valid = 0;
        wait_q("wbh A rd", 0, 1);
        @(negedge clock);
        miss_valid = 1; miss_addr = 26'h600; miss_dirty = 1; miss_victim_addr = 26'h6A0;
        wb_hi = 0;
        @(negedge clock);
        miss_valid = 0; miss_dirty = 0;
        wait_q("wbh B wb", 1, 1);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 0;
        @(negedge clock);
        l2_done = 0;
        #1;
        chk("wbh fill_we", fill_we, 1);
        chk("wbh fill_addr", fill_addr, 26'h500);
        wait_q("wbh B rd", 0, 2);
        chk_rd("wbh B rd", 1, 26'h600, 2'd1);
        if (rd_q.size() > 1 && wb_q.size() > 0) chk("wbh B rd delay", rd_q[1].cyc - wb_q[0].cyc, 4);
        chk("wbh wb_rd_valid cycles", wb_hi, 3);
        @(negedge clock);
        l2_done = 1; l2_done_tag = 1;
        @(negedge clock);
        l2_done = 0;
        @(negedge clock);
        #1;
        chk("wbh count", mshr_count, 0);

        // Done on an unissued tag, then asynchronous reset in the middle of a writeback.
        reset_log();
        @(negedge clock);
        l2_stall = 1;
        miss_valid = 1; miss_addr = 26'h700; miss_dirty = 1; miss_victim_addr = 26'h7A0;
        @(negedge clock);
        miss_valid = 0; miss_dirty = 0;
        l2_done = 1; l2_done_tag = 0;
        @(negedge clock);
        l2_done = 0;
        #1;
        chk("perr set", protocol_err, 1);
        chk("perr no fill", fill_we, 0);
        chk("perr count", mshr_count, 1);
        repeat (3) @(negedge clock);
        #1;
        chk("perr sticky", protocol_err, 1);
        chk("perr nothing issued", rd_q.size() + wb_q.size(), 0);
        @(negedge clock);
        l2_stall = 0;
        wait_q("rst wb", 1, 1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid-wb reset");
        reset_log();
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        chk("post-reset no request", rd_q.size() + wb_q.size(), 0);
        chk("post-reset count", mshr_count, 0);
        chk("post-reset wb_rd_valid", wb_rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mshr_miss_ctrl.md
Name: mshr_miss_ctrl

Overview:
Parametrised non-blocking L1 miss controller with an internal DEPTH-entry MSHR file. It sits between the L1 tag/data arrays and the L2 request port. Multiple misses can be outstanding, and L2 responses may complete out of order (matched by tag). A dirty victim is written back before its refill read. Completion handling runs independently of request issue, so an L2 response is never lost while a writeback is in progress.

Parameters:
ADDR_W, 26, line-address width
DEPTH, 4, MSHR entries (power of 2, ≥2)
TAG_W, log2(DEPTH), L2 transaction tag width (derived, not overridable)
L2_CLK_DIV, 1, L2 clock ratio; writeback data is held for WB_HOLD = 2*L2_CLK_DIV+1 cycles

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low
miss_valid  in  1  L1 lookup missed this cycle
miss_addr  in  ADDR_W  missing line address
miss_dirty  in  1  victim line dirty
miss_victim_addr  in  ADDR_W  victim line address
lookup_valid  in  1  processor request present
lookup_addr  in  ADDR_W  processor request line address
l2_stall  in  1  L2 cannot accept a request
l2_done  in  1  refill data valid
l2_done_tag  in  TAG_W  tag of the completing refill
l2_valid  out  1  L2 request strobe
l2_rw  out  1  1 = writeback, 0 = read
l2_addr  out  ADDR_W  L2 request address
l2_tag  out  TAG_W  MSHR index carried with the read
wb_rd_valid  out  1  read victim data from the L1 array
fill_we  out  1  write refill line into L1
fill_addr  out  ADDR_W  refill line address
stall_out  out  1  hold the processor pipeline
mshr_count  out  TAG_W+1  valid entries
protocol_err  out  1  sticky: l2_done carried an invalid tag

Behaviour:
- Reset (async, low) values:
  - all entries invalid; FSM = IDLE; hold counter 0.
  - every output 0.
- Entry contents: valid, issued, addr, dirty, victim.
- Allocation:
  - Occurs when miss_valid, no free-slot shortage, and miss_addr matches no valid entry.
  - Target slot is the lowest-index free slot, using the free vector registered at the previous edge.
  - A slot freed this cycle is not reusable until the next cycle.
  - A miss while full, or a miss matching a valid entry (secondary miss), is not allocated.
- stall_out is combinational:
  - (lookup_valid & lookup_addr matches any valid entry) | (miss_valid & full).
  - This blocks same-line accesses until fill completes.
- Issue FSM (registered outputs, one request at a time):
  - IDLE: select the lowest-index entry with valid & ~issued. If such an entry exists and ~l2_stall: go to WB_ISSUE if dirty, else RD_ISSUE. Otherwise stay in IDLE.
  - WB_ISSUE: one cycle. l2_valid=1, l2_rw=1, l2_addr=victim, wb_rd_valid=1. Load counter=1. Go to WB_HOLD.
  - WB_HOLD:
    - Outputs: wb_rd_valid=1, l2_valid=0; l2_addr holds victim.
    - Counter increments each cycle.
    - At count==WB_HOLD-1 the counter freezes while l2_stall.
    - At count==WB_HOLD with ~l2_stall, go to RD_ISSUE.
  - RD_ISSUE:
    - Waits while l2_stall.
    - Otherwise outputs l2_valid=1, l2_rw=0, l2_addr=entry addr, l2_tag=index for one cycle.
    - Sets issued, then returns to IDLE.
  - The selected index is latched on leaving IDLE and is stable through the sequence.
- Completion path (independent of the FSM):
  - l2_done with an entry that is valid & issued: next cycle fill_we=1 and fill_addr=entry addr; the entry is freed on that same edge.
  - l2_done for an invalid or unissued tag: ignored, and protocol_err is set until reset.
  - l2_done arriving during WB_ISSUE/WB_HOLD/RD_ISSUE is serviced without disturbing the FSM.
  - l2_done and allocation in the same cycle are both honoured.
- mshr_count is registered and equals the popcount of valid entries.
  - Simultaneous alloc+free leaves it unchanged.
  - It never exceeds DEPTH.
- Reset mid-sequence aborts any L2 request. No partial state survives.

Test Plan:
- Clean miss: miss_addr=0x100, dirty=0, l2_stall=0 → l2_valid read with l2_addr=0x100, tag=0, 2 cycles after miss. l2_done tag 0 three cycles later → fill_we one cycle later, fill_addr=0x100, mshr_count 1→0.
- Dirty miss with WB_HOLD=3: victim 0x2A0 → l2_rw=1 pulse, wb_rd_valid high 3 cycles, then read of the miss line. With l2_stall held 4 cycles at hold end, wb_rd_valid stays high and the read is delayed exactly 4 cycles.
- Four misses 0x10/0x20/0x30/0x40 back-to-back → tags 0-3 issued in order, mshr_count=4. A fifth miss 0x50 → stall_out=1, no allocation. Free tag 2 → next cycle 0x50 allocates into slot 2.
- Out-of-order completion: l2_done tags 3,1,0,2 → fill_addr order 0x40,0x20,0x10,0x30, count reaches 0.
- Same-line: lookup_addr=0x100 while 0x100 is outstanding → stall_out=1 until the fill_we cycle, 0 after. A secondary miss on 0x100 creates no new entry.
- l2_done during WB_HOLD of another entry → fill happens on time and the WB sequence is unaltered. l2_done with an unissued tag → protocol_err=1 and stays set; an async reset mid-WB clears all outputs immediately.
